instr_cache_nway: RTL and testbench
===================================

Name: instr_cache_nway

Overview:
- Parametrised N-way set-associative instruction cache for the fetch stage, with true-LRU replacement, a single-cycle flush (fence.i) and AXI4 burst line refill.
- Sits between instruction fetch and the AXI interconnect.
- Tags and data live in inferred 1-cycle-read RAMs; valid bits and LRU ages live in flops so reset and flush clear them immediately.

Parameters:
- ADDR_SIZE, 32, byte address width.
- CACHE_SIZE, 4096, total data bytes (power of 2).
- BLK_PER_SET, 4, ways (power of 2, 1..8).
- WORDS_PER_LINE, 4, instructions per line (power of 2, 2..16).
- INST_SIZE, 32, instruction and AXI data width.

Ports:
- i_aclk  in  1  clock
- i_areset_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_SIZE  word-aligned fetch address
- o_ready  out  1  request accepted this cycle when i_req&&o_ready
- o_instr_valid  out  1  o_instruction/o_fault valid (1-cycle pulse)
- o_instruction  out  INST_SIZE  fetched instruction
- o_fault  out  1  refill returned an error response
- i_flush  in  1  invalidate all lines
- o_araddr  out  ADDR_SIZE  line-aligned refill address
- o_arlen  out  8  WORDS_PER_LINE-1
- o_arsize  out  3  log2(INST_SIZE/8)
- o_arburst  out  2  2'b01 (INCR)
- o_arvalid  out  1  AR valid
- i_arready  in  1  AR ready
- i_rdata  in  INST_SIZE  read beat
- i_rresp  in  2  beat response
- i_rlast  in  1  last beat
- i_rvalid  in  1  R valid
- o_rready  out  1  R ready

Behaviour:
- Geometry: OFF=log2(WORDS_PER_LINE*INST_SIZE/8); SETS=CACHE_SIZE/(line bytes*BLK_PER_SET); IDX=log2(SETS); tag=i_addr[ADDR_SIZE-1:OFF+IDX]. Defaults: OFF=4, 64 sets, index [9:4], tag [31:10].
- Reset (async): state IDLE; all valid bits 0; ages per way = way index; all outputs 0 except o_arlen, o_arsize, o_arburst, which are constants.
- States: IDLE, LOOKUP, REFILL_AR, REFILL_R, RESPOND.
- IDLE:
  - o_ready=1 unless i_flush.
  - i_flush=1 clears all valid bits and resets ages that cycle; a concurrent i_req is not accepted.
  - Otherwise an accepted req latches the address and goes to LOOKUP.
- LOOKUP (hit):
  - Compare all ways.
  - On hit: o_instr_valid=1, o_instruction = the addressed word, LRU updated.
  - o_ready=1 (back-to-back hits, 1-cycle latency, one fetch per cycle). A new accepted req stays in LOOKUP; otherwise go to IDLE.
  - i_flush during a LOOKUP hit: respond normally, o_ready=0, then flush next cycle in IDLE.
- LOOKUP (miss): o_ready=0 and go to REFILL_AR. The victim is the lowest-index invalid way, else the way whose age is BLK_PER_SET-1.
- REFILL_AR: o_arvalid=1 with o_araddr = the address with offset bits zeroed; hold until i_arready, then go to REFILL_R.
- REFILL_R:
  - o_rready=1. Each beat is stored in the line buffer at an incrementing word index.
  - Any i_rresp!=0 sets a sticky error flag.
  - On i_rlast: go to RESPOND.
- RESPOND:
  - No error: write tag, data and valid to the victim way; LRU update; o_instr_valid=1 with the requested word from the line buffer, o_fault=0.
  - Error: no install, no LRU change; o_instr_valid=1, o_fault=1, o_instruction=0.
  - Then go to IDLE.
- LRU update on hit or fill of way w with old age a: ways with age<a increment; way w goes to 0. Ages stay a permutation of 0..BLK_PER_SET-1.
- i_flush during REFILL_AR, REFILL_R or RESPOND is latched. The burst completes and the response is delivered; the flush executes in the following IDLE cycle, so the just-filled line is also invalidated.
- Reset mid-burst: all state abandoned, the AXI read is dropped, no outputs asserted; the bench must reset the slave too.
- i_req low while o_ready=1: no effect. o_instr_valid is never asserted without a prior accepted request.

Test Plan:
- Cold miss on 0x0000_0104:
  - AR araddr=0x100, arlen=3, arsize=2, arburst=1.
  - Beats 0xA0..0xA3 → exactly one o_instr_valid with o_instruction=0xA1, o_fault=0; o_ready low throughout the refill.
- Hit after fill: req 0x108 on the cycle after RESPOND, then 0x10C the next cycle → o_instr_valid on consecutive cycles with 0xA2 and 0xA3; no AR issued.
- LRU eviction on set 0:
  - Fill 0x000, 0x400, 0x800, 0xC00 (ways 0..3), then hit 0x000.
  - Miss 0x1000 evicts the 0x400 way (AR 0x1000).
  - Then 0x000 hits and 0x400 misses (AR 0x400).
- Flush:
  - After filling 0x100, pulse i_flush in IDLE → o_ready=0 that cycle; next req 0x104 misses (AR 0x100).
  - Flush asserted mid-burst → response delivered, then the line is invalid.
- Error refill: beat 2 has rresp=2'b10 → o_instr_valid=1, o_fault=1, o_instruction=0; a repeat req to the same address misses again.
- Reset asserted after beat 1 of a refill → outputs 0 immediately; after release and slave reset, req 0x104 misses and completes normally.

Source files
------------

// File: rtl/instr_cache_nway.sv
// N-way set-associative instruction cache with true-LRU replacement, single-cycle
// flush and AXI4 INCR burst line refill. Tags/data in 1-cycle-read RAMs, valid/age in flops.
module instr_cache_nway #(
  parameter int ADDR_SIZE      = 32,
  parameter int CACHE_SIZE     = 4096,
  parameter int BLK_PER_SET    = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int INST_SIZE      = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_req,
  input  logic [ADDR_SIZE-1:0] i_addr,
  output logic                 o_ready,
  output logic                 o_instr_valid,
  output logic [INST_SIZE-1:0] o_instruction,
  output logic                 o_fault,
  input  logic                 i_flush,
  output logic [ADDR_SIZE-1:0] o_araddr,
  output logic [7:0]           o_arlen,
  output logic [2:0]           o_arsize,
  output logic [1:0]           o_arburst,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  input  logic [INST_SIZE-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  input  logic                 i_rlast,
  input  logic                 i_rvalid,
  output logic                 o_rready
);
  localparam int LINE_BYTES = WORDS_PER_LINE * INST_SIZE / 8;
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int SETS  = CACHE_SIZE / (LINE_BYTES * BLK_PER_SET);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_SIZE - OFF - IDX;
  localparam int WOFF  = $clog2(WORDS_PER_LINE);
  localparam int BOFF  = $clog2(INST_SIZE / 8);
  localparam int WAYW  = (BLK_PER_SET > 1) ? $clog2(BLK_PER_SET) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL_AR, S_REFILL_R, S_RESPOND} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WAYW-1:0]        victim_q, victim_d;
  logic [WOFF-1:0]        beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   run_q;
  logic [INST_SIZE-1:0]   line_q [WORDS_PER_LINE];
  logic [SETS-1:0]        valid_q [BLK_PER_SET];
  logic [WAYW-1:0]        age_q [BLK_PER_SET][SETS];

  logic [TAG_W-1:0]       tag_rd [BLK_PER_SET];
  logic [INST_SIZE-1:0]   data_rd [BLK_PER_SET][WORDS_PER_LINE];
  logic [WAYW-1:0]        new_age [BLK_PER_SET];
  logic [WAYW-1:0]        hit_way, vict, touch_way, old_age;
  logic                   hit, found, touch_en, flush_now, accept, install;
  logic                   unused_addr_bits;

  wire [IDX-1:0]   idx    = addr_q[OFF+IDX-1:OFF];
  wire [TAG_W-1:0] tag    = addr_q[ADDR_SIZE-1:OFF+IDX];
  wire [WOFF-1:0]  word   = addr_q[OFF-1:BOFF];
  wire [IDX-1:0]   rd_idx = i_addr[OFF+IDX-1:OFF];

  assign accept           = i_req && o_ready;
  assign install          = (state_q == S_RESPOND) && !err_q;
  assign unused_addr_bits = ^addr_q[BOFF-1:0];
  assign o_arlen          = 8'(WORDS_PER_LINE - 1);
  assign o_arsize         = 3'(BOFF);
  assign o_arburst        = 2'b01;

  // RAMs are read on request acceptance so the result is ready in LOOKUP.
  for (genvar gi = 0; gi < BLK_PER_SET; gi++) begin : g_way
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [TAG_W-1:0] tag_rd_q;
    always_ff @(posedge i_aclk) begin
      if (install && victim_q == WAYW'(gi)) tag_mem[idx] <= tag;
      if (accept) tag_rd_q <= tag_mem[rd_idx];
    end
    assign tag_rd[gi] = tag_rd_q;
    for (genvar gj = 0; gj < WORDS_PER_LINE; gj++) begin : g_word
      logic [INST_SIZE-1:0] data_mem [SETS];
      logic [INST_SIZE-1:0] data_rd_q;
      always_ff @(posedge i_aclk) begin
        if (install && victim_q == WAYW'(gi)) data_mem[idx] <= line_q[gj];
        if (accept) data_rd_q <= data_mem[rd_idx];
      end
      assign data_rd[gi][gj] = data_rd_q;
    end
  end

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    found = 1'b0;
    vict = '0;
    for (int w = 0; w < BLK_PER_SET; w++) begin
      if (valid_q[w][idx] && tag_rd[w] == tag) begin
        hit = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!found && !valid_q[w][idx]) begin
        found = 1'b1;
        vict = WAYW'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < BLK_PER_SET; w++)
        if (age_q[w][idx] == WAYW'(BLK_PER_SET - 1)) vict = WAYW'(w);
    end
  end

  // Touched way becomes youngest; only ways younger than it age by one.
  always_comb begin
    touch_en = install;
    touch_way = victim_q;
    if (state_q == S_LOOKUP && hit) begin
      touch_en = 1'b1;
      touch_way = hit_way;
    end
    old_age = age_q[touch_way][idx];
    for (int w = 0; w < BLK_PER_SET; w++) begin
      new_age[w] = age_q[w][idx];
      if (WAYW'(w) == touch_way) new_age[w] = '0;
      else if (age_q[w][idx] < old_age) new_age[w] = age_q[w][idx] + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    victim_d = victim_q;
    beat_d = beat_q;
    err_d = err_q;
    flush_pend_d = flush_pend_q;
    flush_now = 1'b0;
    o_ready = 1'b0;
    o_instr_valid = 1'b0;
    o_instruction = '0;
    o_fault = 1'b0;
    o_araddr = '0;
    o_arvalid = 1'b0;
    o_rready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_flush || flush_pend_q) begin
          flush_now = 1'b1;
          flush_pend_d = 1'b0;
        end else begin
          o_ready = run_q;
          if (i_req && run_q) begin
            addr_d = i_addr;
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          o_instr_valid = 1'b1;
          o_instruction = data_rd[hit_way][word];
          if (i_flush) begin
            state_d = S_IDLE;
          end else begin
            o_ready = 1'b1;
            if (i_req) addr_d = i_addr;
            else state_d = S_IDLE;
          end
        end else begin
          victim_d = vict;
          beat_d = '0;
          err_d = 1'b0;
          state_d = S_REFILL_AR;
        end
      end
      S_REFILL_AR: begin
        o_arvalid = 1'b1;
        o_araddr = {addr_q[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
        if (i_arready) state_d = S_REFILL_R;
      end
      S_REFILL_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          beat_d = beat_q + 1'b1;
          if (i_rresp != 2'b00) err_d = 1'b1;
          if (i_rlast) state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        o_instr_valid = 1'b1;
        o_fault = err_q;
        o_instruction = err_q ? '0 : line_q[word];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && i_flush) flush_pend_d = 1'b1;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      victim_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
      flush_pend_q <= 1'b0;
      run_q <= 1'b0;
      for (int j = 0; j < WORDS_PER_LINE; j++) line_q[j] <= '0;
      for (int w = 0; w < BLK_PER_SET; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) age_q[w][s] <= WAYW'(w);
      end
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      victim_q <= victim_d;
      beat_q <= beat_d;
      err_q <= err_d;
      flush_pend_q <= flush_pend_d;
      run_q <= 1'b1;
      if (state_q == S_REFILL_R && i_rvalid) line_q[beat_q] <= i_rdata;
      if (flush_now) begin
        for (int w = 0; w < BLK_PER_SET; w++) begin
          valid_q[w] <= '0;
          for (int s = 0; s < SETS; s++) age_q[w][s] <= WAYW'(w);
        end
      end else begin
        if (install) valid_q[victim_q][idx] <= 1'b1;
        if (touch_en)
          for (int w = 0; w < BLK_PER_SET; w++) age_q[w][idx] <= new_age[w];
      end
    end
  end
endmodule

// File: tb/tb_instr_cache_nway.sv
// Randomised bench for instr_cache_nway: acts as the AXI slave and predicts hits
// with a timestamp-based LRU model of resident lines.
module tb_instr_cache_nway;
  localparam int SETS = 64;
  localparam int WAYS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush, i_arready, i_rvalid, i_rlast;
  logic [31:0] i_addr, i_rdata;
  logic [1:0]  i_rresp;
  logic        o_ready, o_instr_valid, o_fault, o_arvalid, o_rready;
  logic [31:0] o_instruction, o_araddr;
  logic [7:0]  o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;

  int n_chk = 0, n_pass = 0;
  int valid_cnt = 0, valid_exp = 0, ar_cnt = 0, ar_exp = 0;

  bit          mdl_valid [SETS][WAYS];
  logic [31:0] mdl_line  [SETS][WAYS];
  int          mdl_time  [SETS][WAYS];
  int          mdl_now = 0;

  instr_cache_nway dut (
    .i_aclk(clk), .i_areset_n(rst_n), .i_req(i_req), .i_addr(i_addr),
    .o_ready(o_ready), .o_instr_valid(o_instr_valid), .o_instruction(o_instruction),
    .o_fault(o_fault), .i_flush(i_flush), .o_araddr(o_araddr), .o_arlen(o_arlen),
    .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_instr_valid) valid_cnt++;
    if (o_arvalid && i_arready) ar_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  function automatic int mdl_find(input logic [31:0] a);
    int s = int'((a >> 4) & 32'h3F);
    for (int w = 0; w < WAYS; w++)
      if (mdl_valid[s][w] && mdl_line[s][w] == (a & ~32'hF)) return w;
    return -1;
  endfunction

  task automatic mdl_touch(input logic [31:0] a);
    int s = int'((a >> 4) & 32'h3F);
    int w = mdl_find(a);
    mdl_now++;
    if (w >= 0) mdl_time[s][w] = mdl_now;
  endtask

  task automatic mdl_fill(input logic [31:0] a);
    int s = int'((a >> 4) & 32'h3F);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && !mdl_valid[s][w]) v = w;
    if (v < 0) begin
      v = 0;
      for (int w = 1; w < WAYS; w++)
        if (mdl_time[s][w] < mdl_time[s][v]) v = w;
    end
    mdl_now++;
    mdl_valid[s][v] = 1'b1;
    mdl_line[s][v] = a & ~32'hF;
    mdl_time[s][v] = mdl_now;
  endtask

  task automatic mdl_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mdl_valid[s][w] = 1'b0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    i_req = 1'b1;
    i_addr = $urandom & 32'hFFFC;
    @(negedge clk);
    check("flush_ready", o_ready, 0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_req = 1'b0;
    mdl_flush();
    $display("flush");
  endtask

  // Two back-to-back hits; the caller guarantees both lines are resident.
  task automatic do_pair(input logic [31:0] a, input logic [31:0] b);
    i_req = 1'b1;
    i_addr = a;
    @(negedge clk);
    check("pair_ready0", o_ready, 1);
    @(posedge clk); #1;
    i_addr = b;
    @(negedge clk);
    check("pair_valid_a", o_instr_valid, 1);
    check("pair_instr_a", o_instruction, mem_word(a));
    check("pair_ready_a", o_ready, 1);
    mdl_touch(a);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check("pair_valid_b", o_instr_valid, 1);
    check("pair_instr_b", o_instruction, mem_word(b));
    mdl_touch(b);
    valid_exp += 2;
    @(posedge clk); #1;
    $display("pair %h %h hit hit", a, b);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int err_beat, input int flush_beat,
                          input int rst_beat);
    bit hit, done, err;
    int n, dly, gap;
    logic [31:0] line;
    line = a & ~32'hF;
    hit = (mdl_find(a) >= 0);
    err = 1'b0;
    i_req = 1'b1;
    i_addr = a;
    @(negedge clk);
    check("idle_ready", o_ready, 1);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    check("lookup_valid", o_instr_valid, hit);
    if (hit) begin
      check("hit_instr", o_instruction, mem_word(a));
      check("hit_fault", o_fault, 0);
      check("hit_ready", o_ready, 1);
      mdl_touch(a);
      valid_exp++;
      @(posedge clk); #1;
      $display("fetch %h hit", a);
      return;
    end
    check("miss_ready", o_ready, 0);
    @(posedge clk); #1;
    dly = $urandom_range(0, 2);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      i_arready = (n >= dly);
      @(negedge clk);
      if (o_arvalid && i_arready) done = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!done) begin
      check("ar_timeout", 0, 1);
      i_arready = 1'b0;
      return;
    end
    check("araddr", o_araddr, line);
    check("arlen", o_arlen, 3);
    check("arsize", o_arsize, 2);
    check("arburst", o_arburst, 1);
    ar_exp++;
    @(posedge clk); #1;
    i_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      gap = $urandom_range(0, 1);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      i_rvalid = 1'b1;
      i_rdata = mem_word(line + 32'(4 * b));
      i_rresp = (b == err_beat) ? 2'b10 : 2'b00;
      i_rlast = (b == 3);
      i_flush = (b == flush_beat);
      if (b == err_beat) err = 1'b1;
      @(negedge clk);
      check("beat_rready", o_rready, 1);
      check("beat_ready", o_ready, 0);
      @(posedge clk); #1;
      i_rvalid = 1'b0;
      i_rlast = 1'b0;
      i_rresp = 2'b00;
      i_flush = 1'b0;
      if (b == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_instr_valid, 0);
        check("rst_arvalid", o_arvalid, 0);
        check("rst_rready", o_rready, 0);
        mdl_flush();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("fetch %h reset after beat %0d", a, b);
        return;
      end
    end
    @(negedge clk);
    check("resp_valid", o_instr_valid, 1);
    check("resp_fault", o_fault, err);
    check("resp_instr", o_instruction, err ? 32'h0 : mem_word(a));
    valid_exp++;
    if (!err) mdl_fill(a);
    @(posedge clk); #1;
    if (flush_beat >= 0) begin
      mdl_flush();
      @(negedge clk);
      check("pend_flush_ready", o_ready, 0);
      @(posedge clk); #1;
    end
    $display("fetch %h miss err=%0d flush=%0d", a, err, flush_beat >= 0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b0;
    i_req = 1'b0;
    i_addr = '0;
    i_flush = 1'b0;
    i_arready = 1'b0;
    i_rvalid = 1'b0;
    i_rdata = '0;
    i_rresp = 2'b00;
    i_rlast = 1'b0;
    mdl_flush();
    repeat (2) @(negedge clk);
    check("reset_ready", o_ready, 0);
    check("reset_valid", o_instr_valid, 0);
    check("reset_fault", o_fault, 0);
    check("reset_instr", o_instruction, 0);
    check("reset_arvalid", o_arvalid, 0);
    check("reset_araddr", o_araddr, 0);
    check("reset_rready", o_rready, 0);
    check("reset_arlen", o_arlen, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_fetch(32'h104, -1, -1, -1);
    do_pair(32'h108, 32'h10C);
    do_flush();
    do_fetch(32'h104, -1, -1, -1);
    for (int i = 0; i < 4; i++) do_fetch(32'(i) << 10, -1, -1, -1);
    do_fetch(32'h000, -1, -1, -1);
    do_fetch(32'h1000, -1, -1, -1);
    do_fetch(32'h000, -1, -1, -1);
    do_fetch(32'h400, -1, -1, -1);
    do_fetch(32'h204, -1, 2, -1);
    do_fetch(32'h204, -1, -1, -1);
    do_fetch(32'h308, 2, -1, -1);
    do_fetch(32'h308, -1, -1, -1);
    do_flush();
    do_fetch(32'h104, -1, -1, 1);
    do_fetch(32'h104, -1, -1, -1);

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      b = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 15) == 0) do_flush();
      else if (mdl_find(a) >= 0 && mdl_find(b) >= 0 && $urandom_range(0, 1) == 1) do_pair(a, b);
      else do_fetch(a, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("valid_pulse_count", 32'(valid_cnt), 32'(valid_exp));
    check("ar_handshake_count", 32'(ar_cnt), 32'(ar_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
